// File: rtl/alu_shift_sequencer_pkg.sv
// alu_shift_sequencer_pkg: shared op codes, FSM states and datapath constants for the iterative shifter
package alu_shift_sequencer_pkg;
    localparam int WIDTH = 32;
    localparam int SHAMT_W = 5;
    localparam int DEF_STEP_MAX = 7;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/alu_shift_sequencer_step_select.sv
// shift_step_select: one step of the iterative shifter, picking among 8 shifted copies of value
module shift_step_select
    import alu_shift_sequencer_pkg::*;
(
    input  op_t              op,
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] shifted
);
    logic [WIDTH-1:0] cand [8];
    for (genvar k = 0; k < 8; k++) begin : g_cand
        localparam int L = (WIDTH - k) % WIDTH;
        assign cand[k] = op == OP_SLL ? value << k :
                         op == OP_SRL ? value >> k :
                         op == OP_SRA ? $unsigned($signed(value) >>> k) :
                                        (value >> k) | (value << L);
    end
    assign shifted = cand[select];
endmodule

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer: start/busy/done controller applying up to STEP_MAX bits of shift per cycle
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int STEP_MAX = DEF_STEP_MAX
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         step_sel
);
    state_t             state;
    op_t                op_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   next_acc;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] rem_next;
    logic [2:0]         step;
    always_comb begin
        step = state == S_SHIFT ? (rem > SHAMT_W'(STEP_MAX) ? 3'(STEP_MAX) : rem[2:0]) : 3'd0;
        rem_next = rem - SHAMT_W'(step);
    end
    shift_step_select u_step (
        .op      (op_r),
        .value   (acc),
        .select  (step),
        .shifted (next_acc)
    );
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign step_sel = step;
    // result is loaded on the transition into DONE so it is valid alongside done
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            op_r   <= OP_SLL;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    acc  <= operand;
                    rem  <= shamt;
                    op_r <= op_t'(op);
                    if (shamt == '0) begin
                        state  <= S_DONE;
                        result <= operand;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc <= next_acc;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state  <= S_DONE;
                        result <= next_acc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb_alu_shift_sequencer: directed table, random ops against an arithmetic model, and handshake corner cases
module tb_alu_shift_sequencer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [2:0]  step_sel;
    int errors = 0;
    int checks = 0;

    alu_shift_sequencer dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .operand  (operand),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .step_sel (step_sel)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] val;
        logic [4:0]  sh;
        logic [31:0] res;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        int n = int'(s);
        case (o)
            2'b00:   return v << n;
            2'b01:   return v >> n;
            2'b10:   return $unsigned($signed(v) >>> n);
            default: return n == 0 ? v : (v >> n) | (v << (32 - n));
        endcase
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issues one op in the current cycle and follows it to done and back to idle
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] v,
                          input logic [4:0] s, input logic [31:0] exp);
        int n = (int'(s) + 6) / 7;
        int left;
        bit seen = 0;
        op = o; operand = v; shamt = s; start = 1'b1;
        tick;
        start = 1'b0; op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
        for (int c = 1; c <= 10; c++) begin
            if (done) begin
                check({name, " latency"}, 32'(c), 32'(n + 1));
                check({name, " result"}, result, exp);
                check({name, " step_sel at done"}, 32'(step_sel), 32'd0);
                seen = 1;
                break;
            end
            check({name, " busy"}, 32'(busy), 32'd1);
            left = int'(s) - 7 * (c - 1);
            check({name, " step_sel"}, 32'(step_sel), 32'(left > 7 ? 7 : left));
            tick;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done never seen, expected in cycle %0d", name, n + 1);
        end
        tick;
        check({name, " idle busy"}, 32'(busy), 32'd0);
        check({name, " result held"}, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int dones;
        vecs[0] = '{"sll1_31",  2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{"sra_4",    2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2] = '{"srl_0",    2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[3] = '{"ror_8",    2'b11, 32'h0000_00FF, 5'd8,  32'hFF00_0000};
        vecs[4] = '{"srl_14",   2'b01, 32'hFFFF_FFFF, 5'd14, 32'h0003_FFFF};
        vecs[5] = '{"sra_pos",  2'b10, 32'h7000_0000, 5'd31, 32'h0000_0000};
        vecs[6] = '{"sra_neg",  2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
        vecs[7] = '{"ror_4",    2'b11, 32'h1234_5678, 5'd4,  32'h8123_4567};
        vecs[8] = '{"sll_7",    2'b00, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FF80};

        tick;
        tick;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset step_sel", 32'(step_sel), 32'd0);
        reset_n = 1'b1;
        tick;

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].val, vecs[i].sh, vecs[i].res);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o = 2'($urandom_range(0, 3));
            logic [31:0] v = $urandom;
            logic [4:0]  s = 5'($urandom_range(0, 31));
            run_op("random", o, v, s, model(o, v, s));
        end

        // start pulses while busy are dropped; the next idle-cycle start is taken
        op = 2'b00; operand = 32'h1; shamt = 5'd20; start = 1'b1;
        tick;
        operand = 32'hFFFF_FFFF; shamt = 5'd31; op = 2'b11;
        check("busy_start c1 busy", 32'(busy), 32'd1);
        tick;
        start = 1'b0;
        tick;
        tick;
        start = 1'b1;
        check("busy_start done c4", 32'(done), 32'd1);
        check("busy_start result", result, 32'h0010_0000);
        op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd4;
        tick;
        check("busy_start c5 idle", 32'(busy), 32'd0);
        check("busy_start c5 result held", result, 32'h0010_0000);
        tick;
        start = 1'b0;
        check("next_start busy", 32'(busy), 32'd1);
        check("next_start step", 32'(step_sel), 32'd4);
        tick;
        check("next_start done", 32'(done), 32'd1);
        check("next_start result", result, 32'h0FFF_FFFF);
        tick;

        // reset in the middle of an op discards it
        op = 2'b00; operand = 32'h1; shamt = 5'd31; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        reset_n = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        reset_n = 1'b1;
        check("mid_reset busy", 32'(busy), 32'd0);
        check("mid_reset done", 32'(done), 32'd0);
        check("mid_reset result", result, 32'd0);
        check("mid_reset step_sel", 32'(step_sel), 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            dones += int'(done);
            tick;
        end
        check("mid_reset no done", 32'(dones), 32'd0);
        run_op("after_reset", 2'b00, 32'h3, 5'd1, 32'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
